psram_acq_sequencer: RTL

//  Upstream command sequencer for the QPI PSRAM controller (psram top).
//  - Write mode: turns a sample-FIFO stream into back-to-back write bursts.
//    It generates address/read_write/quad_start/burst_mode/stop_acquisition
//    and tracks the next word address from next_write pulses.
//  - Readback mode: issues single-word reads for the dump path.
//  - Waits for qpi_on before issuing any command; flags full memory and stalled commands.

---
 rtl/psram_pkg.sv | 21 ++
 rtl/psram_addr_tracker.sv | 69 ++++++
 rtl/psram_acq_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/psram_pkg.sv
// Shared definitions for the QPI PSRAM controller and its upstream acquisition sequencer.
package psram_pkg;

  localparam logic [1:0] RW_IDLE  = 2'd0;
  localparam logic [1:0] RW_WRITE = 2'd1;
  localparam logic [1:0] RW_READ  = 2'd2;

  // PAGE_BYTES must stay a power of two; BURST_MAX matches the controller TIMER+1.
  localparam int unsigned PAGE_BYTES = 1024;
  localparam int unsigned BURST_MAX  = 117;

  typedef enum logic [2:0] {
    StIdle,
    StWrIssue,
    StWrWait,
    StWrGap,
    StRdIssue,
    StRdWait
  } seq_state_e;

endpackage

// File: rtl/psram_addr_tracker.sv
// Write-pointer bookkeeping: next word address, page-room test, full/wrap flags, word count.
// PSRAM_RING_WRAP_EN selects circular addressing instead of stopping at ADDR_LAST.
module psram_addr_tracker
  import psram_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 23,
  parameter int unsigned       WORD_BYTES = 2,
  parameter logic [ADDR_W-1:0] ADDR_LAST  = {{(ADDR_W-1){1'b1}}, 1'b0}
) (
  input  logic              clk_PSRAM,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              step,
  output logic [ADDR_W-1:0] next_addr,
  output logic [ADDR_W-1:0] words_written,
  output logic              room_burst,
  output logic              last_word,
  output logic              mem_full,
  output logic              wrapped
);

  localparam int unsigned       PageW = $clog2(PAGE_BYTES);
  localparam logic [ADDR_W-1:0] Step  = ADDR_W'(WORD_BYTES);

  logic [PageW-1:0] page_off;
  logic             at_last;

  assign page_off   = next_addr[PageW-1:0];
  assign at_last    = (next_addr == ADDR_LAST);
  assign room_burst = (32'(page_off) + WORD_BYTES * BURST_MAX) <= PAGE_BYTES;
  // The word at next_addr is the final one before a page or memory boundary.
  assign last_word  = at_last || (page_off == PageW'(PAGE_BYTES - WORD_BYTES));

  always_ff @(posedge clk_PSRAM or negedge rst_n) begin
    if (!rst_n) begin
      next_addr     <= '0;
      words_written <= '0;
      mem_full      <= 1'b0;
    end else if (clear) begin
      next_addr     <= '0;
      words_written <= '0;
      mem_full      <= 1'b0;
    end else if (step && !mem_full) begin
      if (words_written != '1) words_written <= words_written + ADDR_W'(1);
      if (at_last) begin
`ifdef PSRAM_RING_WRAP_EN
        next_addr <= '0;
`else
        mem_full  <= 1'b1;
`endif
      end else begin
        next_addr <= next_addr + Step;
      end
    end
  end

`ifdef PSRAM_RING_WRAP_EN
  logic wrapped_q;
  always_ff @(posedge clk_PSRAM or negedge rst_n) begin
    if (!rst_n)                     wrapped_q <= 1'b0;
    else if (clear)                 wrapped_q <= 1'b0;
    else if (step && at_last)       wrapped_q <= 1'b1;
  end
  assign wrapped = wrapped_q;
`else
  assign wrapped = 1'b0;
`endif

endmodule

// File: rtl/psram_acq_sequencer.sv
// Command sequencer feeding the QPI PSRAM controller: FIFO-driven write bursts and single-word
// readback. Optional circular buffer mode via PSRAM_RING_WRAP_EN (see psram_addr_tracker).
module psram_acq_sequencer
  import psram_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 23,
  parameter int unsigned       WORD_BYTES  = 2,
  parameter logic [ADDR_W-1:0] ADDR_LAST   = {{(ADDR_W-1){1'b1}}, 1'b0},
  parameter int unsigned       CMD_TIMEOUT = 4096
) (
  input  logic              clk_PSRAM,
  input  logic              rst_n,
  input  logic              qpi_on,
  input  logic              acq_start,
  input  logic              acq_stop,
  input  logic              fifo_empty,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              endcommand,
  input  logic              next_write,
  output logic [ADDR_W-1:0] address,
  output logic [1:0]        read_write,
  output logic              quad_start,
  output logic              burst_mode,
  output logic              stop_acquisition,
  output logic [ADDR_W-1:0] words_written,
  output logic              busy,
  output logic              mem_full,
  output logic              wrapped,
  output logic              rd_done,
  output logic              cmd_error
);

  localparam int unsigned       TmoW     = $clog2(CMD_TIMEOUT);
  localparam logic [TmoW-1:0]   TmoLast  = TmoW'(CMD_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] WordMask = {{(ADDR_W-1){1'b1}}, 1'b0};

  seq_state_e        state;
  logic              stop_pend;
  logic [TmoW-1:0]   tmo_cnt;
  logic [ADDR_W-1:0] next_addr;
  logic              room_burst;
  logic              last_word;
  logic              trk_clear;
  logic              trk_step;

  assign trk_clear = (state == StIdle) && qpi_on && acq_start;
  assign trk_step  = (state == StWrWait) && next_write;
  assign busy      = (state != StIdle);
  assign rd_done   = (state == StRdWait) && endcommand;

  psram_addr_tracker #(
    .ADDR_W     (ADDR_W),
    .WORD_BYTES (WORD_BYTES),
    .ADDR_LAST  (ADDR_LAST)
  ) u_addr_tracker (
    .clk_PSRAM     (clk_PSRAM),
    .rst_n         (rst_n),
    .clear         (trk_clear),
    .step          (trk_step),
    .next_addr     (next_addr),
    .words_written (words_written),
    .room_burst    (room_burst),
    .last_word     (last_word),
    .mem_full      (mem_full),
    .wrapped       (wrapped)
  );

  always_ff @(posedge clk_PSRAM or negedge rst_n) begin
    if (!rst_n) begin
      state            <= StIdle;
      address          <= '0;
      read_write       <= RW_IDLE;
      quad_start       <= 1'b0;
      burst_mode       <= 1'b0;
      stop_acquisition <= 1'b1;
      cmd_error        <= 1'b0;
      stop_pend        <= 1'b0;
      tmo_cnt          <= '0;
    end else begin
      quad_start <= 1'b0;
      unique case (state)
        StIdle: begin
          if (qpi_on) begin
            if (acq_start) begin
              stop_pend <= 1'b0;
              state     <= StWrGap;
            end else if (rd_req) begin
              address    <= rd_addr & WordMask;
              read_write <= RW_READ;
              quad_start <= 1'b1;
              state      <= StRdIssue;
            end
          end
        end
        StWrGap: begin
          if (stop_pend || acq_stop || mem_full) begin
            stop_acquisition <= 1'b1;
            state            <= StIdle;
          end else if (!fifo_empty) begin
            address          <= next_addr;
            read_write       <= RW_WRITE;
            quad_start       <= 1'b1;
            burst_mode       <= room_burst;
            stop_acquisition <= 1'b0;
            state            <= StWrIssue;
          end
        end
        StWrIssue: begin
          tmo_cnt <= '0;
          if (acq_stop) stop_acquisition <= 1'b1;
          state <= StWrWait;
        end
        StWrWait: begin
          // Single-word commands and boundary words must not be extended by the controller.
          if (acq_stop || (next_write && (last_word || !burst_mode))) stop_acquisition <= 1'b1;
          if (endcommand) begin
            read_write       <= RW_IDLE;
            burst_mode       <= 1'b0;
            stop_acquisition <= 1'b1;
            state            <= StWrGap;
          end else if (tmo_cnt == TmoLast) begin
            cmd_error        <= 1'b1;
            read_write       <= RW_IDLE;
            burst_mode       <= 1'b0;
            stop_acquisition <= 1'b1;
            state            <= StIdle;
          end else begin
            tmo_cnt <= tmo_cnt + TmoW'(1);
          end
        end
        StRdIssue: begin
          tmo_cnt <= '0;
          state   <= StRdWait;
        end
        StRdWait: begin
          if (endcommand) begin
            read_write <= RW_IDLE;
            state      <= StIdle;
          end else if (tmo_cnt == TmoLast) begin
            cmd_error        <= 1'b1;
            read_write       <= RW_IDLE;
            stop_acquisition <= 1'b1;
            state            <= StIdle;
          end else begin
            tmo_cnt <= tmo_cnt + TmoW'(1);
          end
        end
        default: state <= StIdle;
      endcase
      if (acq_stop && (state inside {StWrGap, StWrIssue, StWrWait})) stop_pend <= 1'b1;
    end
  end

endmodule
